// File: rtl/multi_accumulator.sv
// multi_accumulator
//   Bank of CHANNELS independent signed accumulators sharing one operation port.
//   Each accepted operation computes either (in_up - in_down) for a clear, or
//   (acc[in_ch] + in_up - in_down) otherwise. The exact result is formed at
//   WIDTH+2 bits so that overflow of the WIDTH-bit accumulator can be detected.
//   The accumulator is written on the accepting edge, so back-to-back operations
//   on one channel chain without a stall. The result is presented one cycle
//   later through a single-entry valid/ready output register.
//
//   Build option: define ACC_SATURATE_EN to clamp overflowing results to the
//   signed range; otherwise they wrap to the low WIDTH bits. Overflow flagging
//   is the same in both builds.
//
// Parameters
//   WIDTH     accumulator / operand width in bits (8..64)
//   CHANNELS  number of accumulators (2..16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operation offered
//   in_ready   operation can be accepted (= !out_valid || out_ready)
//   in_ch      target channel
//   in_clear   load (in_up - in_down) instead of accumulating
//   in_up      signed addend
//   in_down    signed subtrahend
//   out_valid  result held
//   out_ready  result consumed
//   out_ch     channel of held result
//   out_sum    new value of that channel
//   out_ovf    that operation overflowed
//   ovf_flags  sticky per-channel overflow flags

module multi_accumulator #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(CHANNELS)-1:0] in_ch,
    input  logic                        in_clear,
    input  logic [WIDTH-1:0]            in_up,
    input  logic [WIDTH-1:0]            in_down,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(CHANNELS)-1:0] out_ch,
    output logic [WIDTH-1:0]            out_sum,
    output logic                        out_ovf,
    output logic [CHANNELS-1:0]         ovf_flags
);

    localparam int CH_W = $clog2(CHANNELS);
    localparam logic [CH_W:0]    CH_LIMIT = CHANNELS[CH_W:0];
`ifdef ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic [WIDTH-1:0]    out_sum_q, out_sum_d;
    logic                out_ovf_q, out_ovf_d;

    logic                accept;
    logic                ch_ok;
    logic [WIDTH+1:0]    base;
    logic [WIDTH+1:0]    exact;
    logic                ovf;
    logic [WIDTH-1:0]    result;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Out-of-range channels are accepted but otherwise ignored.
    assign ch_ok    = ({1'b0, in_ch} < CH_LIMIT);

    always_comb begin
        base = '0;
        if (!in_clear && ch_ok) begin
            base = {{2{acc_q[in_ch][WIDTH-1]}}, acc_q[in_ch]};
        end
        exact = base
              + {{2{in_up[WIDTH-1]}}, in_up}
              - {{2{in_down[WIDTH-1]}}, in_down};
        // In range exactly when the top three bits are sign copies.
        ovf = !((exact[WIDTH+1:WIDTH-1] == 3'b000) ||
                (exact[WIDTH+1:WIDTH-1] == 3'b111));
`ifdef ACC_SATURATE_EN
        if (ovf) begin
            result = exact[WIDTH+1] ? SAT_MIN : SAT_MAX;
        end else begin
            result = exact[WIDTH-1:0];
        end
`else
        result = exact[WIDTH-1:0];
`endif
    end

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (accept && ch_ok) begin
            acc_d[in_ch] = result;
            if (in_clear) begin
                ovf_d[in_ch] = ovf;
            end else begin
                ovf_d[in_ch] = ovf_q[in_ch] | ovf;
            end
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            out_sum_d   = result;
            out_ovf_d   = ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_multi_accumulator.sv
// tb_multi_accumulator
//   Directed bench for multi_accumulator (WIDTH=32, CHANNELS=4). A table of
//   operations with hand-computed results drives the main function; short
//   hand-written sequences cover backpressure and asynchronous reset.
//   Expected values depend on ACC_SATURATE_EN where overflow occurs.

module tb_multi_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic        in_clear;
    logic [31:0] in_up;
    logic [31:0] in_down;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [31:0] out_sum;
    logic        out_ovf;
    logic [3:0]  ovf_flags;

    int passed;
    int total;

    multi_accumulator #(
        .WIDTH    (32),
        .CHANNELS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_clear  (in_clear),
        .in_up     (in_up),
        .in_down   (in_down),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .ovf_flags (ovf_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ACC_SATURATE_EN
    localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF = 32'h8000_0000;
    localparam logic [31:0] BIG_OVF = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] POS_OVF = 32'h8000_0000;
    localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] BIG_OVF = 32'hFFFF_FFFF;
`endif

    typedef struct {
        logic        vld;
        logic [1:0]  ch;
        logic        clr;
        logic [31:0] up;
        logic [31:0] dn;
        logic        ev;
        logic [31:0] es;
        logic        eo;
        logic [3:0]  ef;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic vld, logic [1:0] ch, logic clr,
                                logic [31:0] up, logic [31:0] dn,
                                logic ev, logic [31:0] es, logic eo,
                                logic [3:0] ef);
        vec_t v;
        v.vld = vld; v.ch = ch; v.clr = clr; v.up = up; v.dn = dn;
        v.ev = ev; v.es = es; v.eo = eo; v.ef = ef;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic vld, logic [1:0] ch, logic clr,
                         logic [31:0] up, logic [31:0] dn);
        in_valid = vld;
        in_ch    = ch;
        in_clear = clr;
        in_up    = up;
        in_down  = dn;
    endtask

    task automatic check_out(string tag, logic [1:0] ch, logic [31:0] sum,
                             logic ovf, logic [3:0] flags);
        check({tag, " valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " ch"},    64'(out_ch),    64'(ch));
        check({tag, " sum"},   64'(out_sum),   64'(sum));
        check({tag, " ovf"},   64'(out_ovf),   64'(ovf));
        check({tag, " flags"}, 64'(ovf_flags), 64'(flags));
    endtask

    initial begin
        passed = 0;
        total  = 0;

        //          vld ch clr up            down          ev es            eo ef
        tbl[0]  = mk(1, 1, 1, 32'd10,        32'd3,        1, 32'd7,        0, 4'h0);
        tbl[1]  = mk(1, 1, 0, 32'd5,         32'd0,        1, 32'd12,       0, 4'h0);
        tbl[2]  = mk(1, 2, 0, 32'd0,         32'd0,        1, 32'd0,        0, 4'h0);
        tbl[3]  = mk(1, 0, 0, 32'd0,         32'd0,        1, 32'd0,        0, 4'h0);
        tbl[4]  = mk(1, 0, 1, 32'h7FFF_FFFF, 32'd0,        1, 32'h7FFF_FFFF, 0, 4'h0);
        tbl[5]  = mk(1, 0, 0, 32'd1,         32'd0,        1, POS_OVF,      1, 4'h1);
        tbl[6]  = mk(1, 0, 0, 32'd0,         32'd0,        1, POS_OVF,      0, 4'h1);
        tbl[7]  = mk(1, 0, 1, 32'd0,         32'd0,        1, 32'd0,        0, 4'h0);
        tbl[8]  = mk(1, 3, 0, 32'd1,         32'd0,        1, 32'd1,        0, 4'h0);
        tbl[9]  = mk(1, 3, 0, 32'd1,         32'd0,        1, 32'd2,        0, 4'h0);
        tbl[10] = mk(1, 3, 0, 32'd1,         32'd0,        1, 32'd3,        0, 4'h0);
        tbl[11] = mk(1, 3, 0, 32'd1,         32'd0,        1, 32'd4,        0, 4'h0);
        tbl[12] = mk(0, 0, 0, 32'd0,         32'd0,        0, 32'd0,        0, 4'h0);
        tbl[13] = mk(1, 2, 1, 32'h8000_0000, 32'd1,        1, NEG_OVF,      1, 4'h4);
        tbl[14] = mk(1, 2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, NEG_OVF,     0, 4'h4);
        tbl[15] = mk(1, 1, 0, 32'd0,         32'd12,       1, 32'd0,        0, 4'h4);
        tbl[16] = mk(1, 1, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1, BIG_OVF,     1, 4'h6);
        tbl[17] = mk(1, 3, 0, 32'd0,         32'd5,        1, 32'hFFFF_FFFF, 0, 4'h6);

        // Reset state
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  64'(in_ready),  64'(1'b1));
        check("reset out_valid", 64'(out_valid), 64'(1'b0));
        check("reset out_sum",   64'(out_sum),   64'(0));
        check("reset flags",     64'(ovf_flags), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven operations
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].vld, tbl[i].ch, tbl[i].clr, tbl[i].up, tbl[i].dn);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", i), 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("vec%0d ch", i),  64'(out_ch),  64'(tbl[i].ch));
                check($sformatf("vec%0d sum", i), 64'(out_sum), 64'(tbl[i].es));
                check($sformatf("vec%0d ovf", i), 64'(out_ovf), 64'(tbl[i].eo));
            end
            check($sformatf("vec%0d flags", i), 64'(ovf_flags), 64'(tbl[i].ef));
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("idle valid", 64'(out_valid), 64'(1'b0));

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        drive(1, 2, 1, 32'd4, 32'd0);
        @(posedge clk);
        #1;
        check_out("bp first", 2, 32'd4, 0, 4'h2);
        drive(1, 2, 0, 32'd1, 32'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp in_ready %0d", k), 64'(in_ready), 64'(1'b0));
            @(posedge clk);
            #1;
            check($sformatf("bp hold sum %0d", k), 64'(out_sum), 64'(32'd4));
            check($sformatf("bp hold valid %0d", k), 64'(out_valid), 64'(1'b1));
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        check_out("bp second", 2, 32'd5, 0, 4'h2);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("bp drain valid", 64'(out_valid), 64'(1'b0));

        // Asynchronous reset while a result is pending
        drive(1, 3, 1, 32'h8000_0000, 32'd1);
        @(posedge clk);
        #1;
        check_out("pre-rst ovf", 3, NEG_OVF, 1, 4'hA);
        drive(1, 1, 1, 32'd100, 32'd0);
        @(posedge clk);
        #1;
        check_out("pre-rst ch1", 1, 32'd100, 0, 4'h8);
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst out_valid", 64'(out_valid), 64'(1'b0));
        check("arst out_sum",   64'(out_sum),   64'(0));
        check("arst out_ch",    64'(out_ch),    64'(0));
        check("arst out_ovf",   64'(out_ovf),   64'(0));
        check("arst flags",     64'(ovf_flags), 64'(0));
        check("arst in_ready",  64'(in_ready),  64'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 1, 0, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        check_out("post-rst ch1", 1, 32'd1, 0, 4'h0);
        drive(1, 3, 0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check_out("post-rst ch3", 3, 32'd0, 0, 4'h0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
